// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel-data alignment pipeline
// Counters present x/y to the renderer; sync/de/colour reach the pins PIPE+1 clocks later.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOR_W  = 1,
  parameter int   PIX_DIV  = 1,
  parameter int   PIPE     = 1,
  parameter int   CW       = 10
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [3*COLOR_W-1:0]   rgb_in,
  output logic [CW-1:0]          x,
  output logic [CW-1:0]          y,
  output logic                   active,
  output logic                   frame_start,
  output logic [COLOR_W-1:0]     R,
  output logic [COLOR_W-1:0]     G,
  output logic [COLOR_W-1:0]     B,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [3:0]    DIV_LAST = 4'(PIX_DIV - 1);
  // One extra bit so a window ending exactly at 2**CW still decodes
  localparam logic [CW:0] HA_W  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] VA_W  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] HS0_W = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS1_W = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] VS0_W = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS1_W = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [3:0]    div_q, div_d;
  logic          run_q, fs_q, fs_d;
  logic          tick;
  logic [CW:0]   x_w, y_w;
  logic          act_raw, hs_raw, vs_raw;
  logic [2:0]    stg_in, dly;

  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic               hs_q, vs_q, de_q;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    div_d = div_q;
    fs_d  = 1'b0;
    if (!enable) begin
      x_d   = '0;
      y_d   = '0;
      div_d = '0;
    end else if (!run_q) begin
      fs_d = 1'b1;
    end else if (tick) begin
      div_d = '0;
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + CW'(1);
        end
      end else begin
        x_d = x_q + CW'(1);
      end
    end else begin
      div_d = div_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q   <= '0;
      y_q   <= '0;
      div_q <= '0;
      run_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      div_q <= div_d;
      run_q <= enable;
      fs_q  <= fs_d;
    end
  end

  assign x_w     = {1'b0, x_q};
  assign y_w     = {1'b0, y_q};
  assign act_raw = run_q && (x_w < HA_W) && (y_w < VA_W);
  assign hs_raw  = run_q && (x_w >= HS0_W) && (x_w < HS1_W);
  assign vs_raw  = run_q && (y_w >= VS0_W) && (y_w < VS1_W);
  // Gating with enable flushes idle into the pipe on the very edge enable drops
  assign stg_in  = enable ? {vs_raw, hs_raw, act_raw} : 3'b000;

  generate
    if (PIPE == 0) begin : g_nopipe
      assign dly = stg_in;
    end else begin : g_pipe
      logic [2:0] sr_q [PIPE];
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PIPE; i++) sr_q[i] <= 3'b000;
        end else begin
          sr_q[0] <= stg_in;
          for (int i = 1; i < PIPE; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign dly = sr_q[PIPE-1];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      de_q <= 1'b0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
    end else begin
      r_q  <= dly[0] ? rgb_in[0 +: COLOR_W]         : '0;
      g_q  <= dly[0] ? rgb_in[COLOR_W +: COLOR_W]   : '0;
      b_q  <= dly[0] ? rgb_in[2*COLOR_W +: COLOR_W] : '0;
      de_q <= dly[0];
      hs_q <= dly[1] ? HS_POL : ~HS_POL;
      vs_q <= dly[2] ? VS_POL : ~VS_POL;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = act_raw;
  assign frame_start = fs_q;
  assign R           = r_q;
  assign G           = g_q;
  assign B           = b_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign de          = de_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a reduced raster
// Expected pin values are queued per clock and popped PIPE clocks later.
module tb_vga_timing_gen;

  localparam int   HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int   VA = 4, VF = 1, VS = 2, VB = 1;
  localparam logic HSP = 1'b0, VSP = 1'b1;
  localparam int   CWD = 2, PD = 2, PP = 3, CW = 4;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   PERIOD = HT * VT * PD;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0;
  logic [3*CWD-1:0] rgb_in = '0;
  logic [CW-1:0] x, y;
  logic active, frame_start, h_sync, v_sync, de;
  logic [CWD-1:0] R, G, B;

  always #5 clock = ~clock;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP), .COLOR_W(CWD), .PIX_DIV(PD), .PIPE(PP), .CW(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .rgb_in(rgb_in),
    .x(x), .y(y), .active(active), .frame_start(frame_start),
    .R(R), .G(G), .B(B), .h_sync(h_sync), .v_sync(v_sync), .de(de)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {logic act; logic hs; logic vs;} pix_t;
  pix_t pq[$];
  int   mx, my, mdiv;
  logic mrun, mfs;
  logic exp_de, exp_hs, exp_vs;
  logic [CWD-1:0] exp_r, exp_g, exp_b;

  function automatic pix_t raw_now();
    pix_t p;
    p.act = mrun && (mx < HA) && (my < VA);
    p.hs  = mrun && (mx >= HA + HF) && (mx < HA + HF + HS);
    p.vs  = mrun && (my >= VA + VF) && (my < VA + VF + VS);
    return p;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mx = 0; my = 0; mdiv = 0; mrun = 1'b0; mfs = 1'b0;
      pq.delete();
      for (int i = 0; i < PP; i++) pq.push_back(3'b000);
      exp_de = 1'b0; exp_r = '0; exp_g = '0; exp_b = '0;
      exp_hs = !HSP; exp_vs = !VSP;
    end else begin
      pix_t e, f;
      e = enable ? raw_now() : 3'b000;
      pq.push_back(e);
      f = pq.pop_front();
      exp_de = f.act;
      exp_r  = f.act ? rgb_in[CWD-1:0] : '0;
      exp_g  = f.act ? rgb_in[2*CWD-1:CWD] : '0;
      exp_b  = f.act ? rgb_in[3*CWD-1:2*CWD] : '0;
      exp_hs = f.hs ? HSP : !HSP;
      exp_vs = f.vs ? VSP : !VSP;
      if (!enable) begin
        mx = 0; my = 0; mdiv = 0; mrun = 1'b0; mfs = 1'b0;
      end else if (!mrun) begin
        mrun = 1'b1; mfs = 1'b1;
      end else begin
        mfs = 1'b0;
        if (mdiv == PD - 1) begin
          mdiv = 0;
          if (mx == HT - 1) begin
            mx = 0;
            if (my == VT - 1) begin
              my = 0; mfs = 1'b1;
            end else my = my + 1;
          end else mx = mx + 1;
        end else mdiv = mdiv + 1;
      end
    end
  end

  int   cyc = 0;
  int   last_fs = -1;
  logic chk_on = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (chk_on) begin
      check("x", 32'(x), 32'(mx));
      check("y", 32'(y), 32'(my));
      check("x_range", 32'(x < HT), 32'd1);
      check("active", 32'(active), 32'(mrun && (mx < HA) && (my < VA)));
      check("frame_start", 32'(frame_start), 32'(mfs));
      check("R", 32'(R), 32'(exp_r));
      check("G", 32'(G), 32'(exp_g));
      check("B", 32'(B), 32'(exp_b));
      check("de", 32'(de), 32'(exp_de));
      check("h_sync", 32'(h_sync), 32'(exp_hs));
      check("v_sync", 32'(v_sync), 32'(exp_vs));
      if (!reset_n || !enable) last_fs = -1;
      else if (frame_start) begin
        if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), 32'(PERIOD));
        last_fs = cyc;
      end
    end
  end

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      rgb_in = 6'($urandom);
    end
  endtask

  task automatic wait_pos(input int tx, input int ty);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (mx == tx && my == ty && mdiv == 0) return;
    end
    check("wait_pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_R"}, 32'(R), 32'd0);
    check({tag, "_G"}, 32'(G), 32'd0);
    check({tag, "_B"}, 32'(B), 32'd0);
    check({tag, "_de"}, 32'(de), 32'd0);
    check({tag, "_hs"}, 32'(h_sync), 32'(!HSP));
    check({tag, "_vs"}, 32'(v_sync), 32'(!VSP));
    check({tag, "_x"}, 32'(x), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1 check_idle("reset");
    check("reset_active", 32'(active), 32'd0);
    repeat (2) @(negedge clock);
    enable = 1'b1;
    chk_on = 1'b1;
    #2 reset_n = 1'b1;

    run_random(300);
    @(negedge clock);
    rgb_in = {2'b11, 2'b00, 2'b10};
    repeat (250) @(negedge clock);

    wait_pos(6, 2);
    enable = 1'b0;
    repeat (10) @(negedge clock);
    check_idle("disabled");
    enable = 1'b1;
    @(negedge clock);
    check("restart_x", 32'(x), 32'd0);
    check("restart_y", 32'(y), 32'd0);
    check("restart_fs", 32'(frame_start), 32'd1);

    run_random(300);
    wait_pos(5, 1);
    #2 reset_n = 1'b0;
    #1 check_idle("async_reset");
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    check("resume_x", 32'(x), 32'd0);
    check("resume_y", 32'(y), 32'd0);
    check("resume_fs", 32'(frame_start), 32'd1);
    run_random(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
